// File: rtl/watering_request_ctrl.sv
// Irrigation request initiator: hysteresis, min/max on-time, post-watering cooldown, latched tank fault.
// Optional build macro RAIN_LOCKOUT_EN adds a rain_detect input that blocks or ends watering.
module watering_request_ctrl #(
   parameter int unsigned MOIST_W  = 8,
   parameter int unsigned LOW_TH   = 64,
   parameter int unsigned HIGH_TH  = 160,
   parameter int unsigned DEEP_TH  = 32,
   parameter int unsigned MIN_ON   = 16,
   parameter int unsigned MAX_ON   = 1024,
   parameter int unsigned COOLDOWN = 256,
   parameter int unsigned CNT_W    = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               tick,
   input  logic               sample_valid,
   input  logic [MOIST_W-1:0] moisture,
   input  logic               tank_empty,
   input  logic               fault_clr,
`ifdef RAIN_LOCKOUT_EN
   input  logic               rain_detect,
`endif
   output logic               watering,
   output logic               splinker_switch,
   output logic               dripper_switch,
   output logic               fault,
   output logic [7:0]         cycles_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WATER = 2'd1,
      COOL  = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [MOIST_W-1:0] LOW_Q   = MOIST_W'(LOW_TH);
   localparam logic [MOIST_W-1:0] HIGH_Q  = MOIST_W'(HIGH_TH);
   localparam logic [MOIST_W-1:0] DEEP_Q  = MOIST_W'(DEEP_TH);
   localparam logic [CNT_W-1:0]   MIN_Q   = CNT_W'(MIN_ON);
   localparam logic [CNT_W-1:0]   MAX_Q   = CNT_W'(MAX_ON);
   localparam logic [CNT_W-1:0]   COOL_Q  = CNT_W'(COOLDOWN);
   localparam logic [CNT_W-1:0]   CNT_SAT = {CNT_W{1'b1}};

   state_t             state;
   logic [MOIST_W-1:0] moist_q;
   logic               seen;
   logic [CNT_W-1:0]   cnt;
   logic               rain_c;
   logic               stop_c;
   logic               deep_c;
   logic [CNT_W-1:0]   cnt_next_c;

`ifdef RAIN_LOCKOUT_EN
   assign rain_c = rain_detect;
`else
   assign rain_c = 1'b0;
`endif

   // Decisions always use the registered sample, so a new sample acts one cycle later.
   assign stop_c     = ((cnt >= MIN_Q) && (moist_q >= HIGH_Q)) || (cnt == MAX_Q);
   assign deep_c     = (moist_q < DEEP_Q);
   assign cnt_next_c = (tick && (cnt != CNT_SAT)) ? cnt + CNT_W'(1) : cnt;

   // Request outputs are written on the same edge as the state so watering and the switch pair move together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         moist_q         <= '1;
         seen            <= 1'b0;
         cnt             <= '0;
         watering        <= 1'b0;
         splinker_switch <= 1'b0;
         dripper_switch  <= 1'b0;
         fault           <= 1'b0;
         cycles_done     <= '0;
      end else begin
         if (sample_valid) begin
            moist_q <= moisture;
            seen    <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (tank_empty) begin
                  state <= FAULT;
                  cnt   <= '0;
                  fault <= 1'b1;
               end else if (seen && (moist_q < LOW_Q) && !rain_c) begin
                  state           <= WATER;
                  cnt             <= '0;
                  watering        <= 1'b1;
                  splinker_switch <= deep_c;
                  dripper_switch  <= !deep_c;
               end
            end

            WATER: begin
               if (tank_empty) begin
                  state           <= FAULT;
                  cnt             <= '0;
                  fault           <= 1'b1;
                  watering        <= 1'b0;
                  splinker_switch <= 1'b0;
                  dripper_switch  <= 1'b0;
               end else if (rain_c || stop_c) begin
                  state           <= COOL;
                  cnt             <= '0;
                  watering        <= 1'b0;
                  splinker_switch <= 1'b0;
                  dripper_switch  <= 1'b0;
                  if (cycles_done != 8'hFF) begin
                     cycles_done <= cycles_done + 8'd1;
                  end
               end else begin
                  cnt <= cnt_next_c;
               end
            end

            COOL: begin
               if (tank_empty) begin
                  state <= FAULT;
                  cnt   <= '0;
                  fault <= 1'b1;
               end else if (cnt == COOL_Q) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt_next_c;
               end
            end

            FAULT: begin
               if (fault_clr && !tank_empty) begin
                  state <= IDLE;
                  fault <= 1'b0;
               end
            end

            default: begin
               state           <= IDLE;
               cnt             <= '0;
               watering        <= 1'b0;
               splinker_switch <= 1'b0;
               dripper_switch  <= 1'b0;
               fault           <= 1'b0;
            end
         endcase
      end
   end

endmodule
